// File: rtl/pose_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : pose_tracker_if
// Purpose  : Camera-sample handshake bundle for the pose tracker. It carries
//            the centroid samples and the end-of-frame strobe.
// Signals  : sample_valid  producer offers a sample
//            sample_ready  tracker accepts the sample on valid && ready
//            sample_id     marker index (0..4 tracked, 5..7 discarded)
//            sample_x/y/z  raw coordinate, 12/12/14 bits
//            frame_done    one-cycle end-of-frame pulse
// Modports : master = camera side, slave = tracker side
// Revision : 1.0 - initial release
// ============================================================================
interface pose_tracker_if;
    logic        sample_valid;
    logic        sample_ready;
    logic [2:0]  sample_id;
    logic [11:0] sample_x;
    logic [11:0] sample_y;
    logic [13:0] sample_z;
    logic        frame_done;

    modport master (
        output sample_valid, sample_id, sample_x, sample_y, sample_z, frame_done,
        input  sample_ready
    );

    modport slave (
        input  sample_valid, sample_id, sample_x, sample_y, sample_z, frame_done,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/pose_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pose_tracker
// Purpose  : Collects per-frame marker centroids (two hands x two points plus
//            head), smooths them exponentially and publishes a complete pose
//            once per camera frame. Markers that go unseen for STALE_FRAMES
//            frames are dropped and reload directly when they reappear.
// Ports    : clk_in          single rising-edge clock
//            rst_in          synchronous active-low reset
//            smp             sample handshake bundle (slave side)
//            hand_*/head_*   published coordinates, 12/12/14 bits
//            marker_present  bit i = marker i tracked
//            pose_valid      all five markers present
//            pose_update     one-cycle pulse when published outputs change
//            frame_overrun   one-cycle pulse when a frame_done is dropped
// Options  : POSE_MIRROR_X_EN - mirror sample_x to 4095 - sample_x on entry
// Revision : 1.0 - initial release
// ============================================================================
module pose_tracker #(
    parameter int SMOOTH_SHIFT = 2,
    parameter int STALE_FRAMES = 8
) (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    pose_tracker_if.slave    smp,
    output logic [11:0]      hand_x_left_bottom,
    output logic [11:0]      hand_y_left_bottom,
    output logic [13:0]      hand_z_left_bottom,
    output logic [11:0]      hand_x_left_top,
    output logic [11:0]      hand_y_left_top,
    output logic [13:0]      hand_z_left_top,
    output logic [11:0]      hand_x_right_bottom,
    output logic [11:0]      hand_y_right_bottom,
    output logic [13:0]      hand_z_right_bottom,
    output logic [11:0]      hand_x_right_top,
    output logic [11:0]      hand_y_right_top,
    output logic [13:0]      hand_z_right_top,
    output logic [11:0]      head_x,
    output logic [11:0]      head_y,
    output logic [13:0]      head_z,
    output logic [4:0]       marker_present,
    output logic             pose_valid,
    output logic             pose_update,
    output logic             frame_overrun
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PUBLISH = 1'b1
    } state_t;

    localparam logic [7:0] C_STALE = 8'(STALE_FRAMES);

    state_t      state_q, state_d;
    logic [11:0] shx_q [5];
    logic [11:0] shy_q [5];
    logic [13:0] shz_q [5];
    logic [11:0] outx_q [5];
    logic [11:0] outy_q [5];
    logic [13:0] outz_q [5];
    logic [7:0]  stale_q [5];
    logic [7:0]  stale_d [5];
    logic [4:0]  present_q, present_d;
    logic [4:0]  drop_d;
    logic [4:0]  fresh_q, seen_q;
    logic        pose_valid_q, pose_update_q, frame_overrun_q;
    logic        w_accept;
    logic [11:0] w_x;

    // shadow + floor((sample - shadow) / 2^SMOOTH_SHIFT); the result always
    // lies between shadow and sample, so truncation never wraps.
    function automatic logic [11:0] smooth12(input logic [11:0] sh, input logic [11:0] s);
        logic signed [12:0] d;
        d = $signed({1'b0, s}) - $signed({1'b0, sh});
        d = d >>> SMOOTH_SHIFT;
        return sh + d[11:0];
    endfunction

    function automatic logic [13:0] smooth14(input logic [13:0] sh, input logic [13:0] s);
        logic signed [14:0] d;
        d = $signed({1'b0, s}) - $signed({1'b0, sh});
        d = d >>> SMOOTH_SHIFT;
        return sh + d[13:0];
    endfunction

`ifdef POSE_MIRROR_X_EN
    assign w_x = 12'd4095 - smp.sample_x;
`else
    assign w_x = smp.sample_x;
`endif

    // Ready is forced low during reset so nothing is consumed while held.
    assign smp.sample_ready = rst_in && (state_q == ST_COLLECT);
    assign w_accept         = smp.sample_valid && smp.sample_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (smp.frame_done) state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_COLLECT;
            default:    state_d = ST_COLLECT;
        endcase
    end

    // Per-marker bookkeeping that takes effect at the publishing edge.
    always_comb begin
        for (int m = 0; m < 5; m++) begin
            stale_d[m] = stale_q[m];
            if (seen_q[m]) begin
                stale_d[m] = 8'd0;
            end else if (stale_q[m] != 8'hFF) begin
                stale_d[m] = stale_q[m] + 8'd1;
            end
        end
    end

    always_comb begin
        for (int m = 0; m < 5; m++) begin
            drop_d[m]    = !seen_q[m] && (stale_d[m] >= C_STALE);
            present_d[m] = seen_q[m] || (present_q[m] && !drop_d[m]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q         <= ST_COLLECT;
            present_q       <= 5'd0;
            fresh_q         <= 5'h1F;
            seen_q          <= 5'd0;
            pose_valid_q    <= 1'b0;
            pose_update_q   <= 1'b0;
            frame_overrun_q <= 1'b0;
            for (int m = 0; m < 5; m++) begin
                shx_q[m]   <= 12'd0;
                shy_q[m]   <= 12'd0;
                shz_q[m]   <= 14'd0;
                outx_q[m]  <= 12'd0;
                outy_q[m]  <= 12'd0;
                outz_q[m]  <= 14'd0;
                stale_q[m] <= 8'd0;
            end
        end else begin
            state_q         <= state_d;
            pose_update_q   <= (state_q == ST_PUBLISH);
            frame_overrun_q <= (state_q == ST_PUBLISH) && smp.frame_done;

            // Accept only happens in COLLECT, so it never overlaps the
            // publish branch below. Ids 5..7 match no marker and vanish.
            if (w_accept) begin
                for (int m = 0; m < 5; m++) begin
                    if (smp.sample_id == 3'(m)) begin
                        seen_q[m] <= 1'b1;
                        if (fresh_q[m]) begin
                            shx_q[m]   <= w_x;
                            shy_q[m]   <= smp.sample_y;
                            shz_q[m]   <= smp.sample_z;
                            fresh_q[m] <= 1'b0;
                        end else begin
                            shx_q[m] <= smooth12(shx_q[m], w_x);
                            shy_q[m] <= smooth12(shy_q[m], smp.sample_y);
                            shz_q[m] <= smooth14(shz_q[m], smp.sample_z);
                        end
                    end
                end
            end

            if (state_q == ST_PUBLISH) begin
                for (int m = 0; m < 5; m++) begin
                    if (seen_q[m]) begin
                        outx_q[m] <= shx_q[m];
                        outy_q[m] <= shy_q[m];
                        outz_q[m] <= shz_q[m];
                    end
                    if (drop_d[m]) fresh_q[m] <= 1'b1;
                    stale_q[m] <= stale_d[m];
                end
                seen_q       <= 5'd0;
                present_q    <= present_d;
                pose_valid_q <= &present_d;
            end
        end
    end

    assign hand_x_left_bottom  = outx_q[0];
    assign hand_y_left_bottom  = outy_q[0];
    assign hand_z_left_bottom  = outz_q[0];
    assign hand_x_left_top     = outx_q[1];
    assign hand_y_left_top     = outy_q[1];
    assign hand_z_left_top     = outz_q[1];
    assign hand_x_right_bottom = outx_q[2];
    assign hand_y_right_bottom = outy_q[2];
    assign hand_z_right_bottom = outz_q[2];
    assign hand_x_right_top    = outx_q[3];
    assign hand_y_right_top    = outy_q[3];
    assign hand_z_right_top    = outz_q[3];
    assign head_x              = outx_q[4];
    assign head_y              = outy_q[4];
    assign head_z              = outz_q[4];
    assign marker_present      = present_q;
    assign pose_valid          = pose_valid_q;
    assign pose_update         = pose_update_q;
    assign frame_overrun       = frame_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pose_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pose_tracker
// Purpose  : Self-checking bench for pose_tracker: directed scenarios plus
//            randomized frames compared against a frame-level pose model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pose_tracker;
    localparam int SHIFT = 2;
    localparam int STALE = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pose_tracker_if sif();

    logic [11:0] o_x [5];
    logic [11:0] o_y [5];
    logic [13:0] o_z [5];
    logic [4:0]  marker_present;
    logic        pose_valid, pose_update, frame_overrun;

    pose_tracker #(.SMOOTH_SHIFT(SHIFT), .STALE_FRAMES(STALE)) dut (
        .clk_in(clk), .rst_in(rst_n), .smp(sif.slave),
        .hand_x_left_bottom(o_x[0]), .hand_y_left_bottom(o_y[0]), .hand_z_left_bottom(o_z[0]),
        .hand_x_left_top(o_x[1]), .hand_y_left_top(o_y[1]), .hand_z_left_top(o_z[1]),
        .hand_x_right_bottom(o_x[2]), .hand_y_right_bottom(o_y[2]), .hand_z_right_bottom(o_z[2]),
        .hand_x_right_top(o_x[3]), .hand_y_right_top(o_y[3]), .hand_z_right_top(o_z[3]),
        .head_x(o_x[4]), .head_y(o_y[4]), .head_z(o_z[4]),
        .marker_present(marker_present), .pose_valid(pose_valid),
        .pose_update(pose_update), .frame_overrun(frame_overrun)
    );

    // Reference model: per-marker smoothed estimate, published pose,
    // missed-frame count and presence.
    int sx [5], sy [5], sz [5];
    int ox [5], oy [5], oz [5];
    int missed [5];
    bit fresh [5], seen [5], present [5];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Moves a fraction 1/2^k of the way towards the sample, rounding down.
    function automatic int approach(input int est, input int s, input int k);
        int diff, step;
        diff = s - est;
        if (diff >= 0) step = diff / (1 << k);
        else           step = -((-diff + (1 << k) - 1) / (1 << k));
        return est + step;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 5; m++) begin
            sx[m] = 0; sy[m] = 0; sz[m] = 0;
            ox[m] = 0; oy[m] = 0; oz[m] = 0;
            missed[m] = 0; fresh[m] = 1; seen[m] = 0; present[m] = 0;
        end
    endtask

    task automatic model_sample(input int id, input int x, input int y, input int z);
        int xm;
`ifdef POSE_MIRROR_X_EN
        xm = 4095 - x;
`else
        xm = x;
`endif
        if (id < 5) begin
            if (fresh[id]) begin
                sx[id] = xm; sy[id] = y; sz[id] = z; fresh[id] = 0;
            end else begin
                sx[id] = approach(sx[id], xm, SHIFT);
                sy[id] = approach(sy[id], y, SHIFT);
                sz[id] = approach(sz[id], z, SHIFT);
            end
            seen[id] = 1;
        end
    endtask

    task automatic model_publish();
        for (int m = 0; m < 5; m++) begin
            if (seen[m]) begin
                ox[m] = sx[m]; oy[m] = sy[m]; oz[m] = sz[m];
                missed[m] = 0; present[m] = 1;
            end else begin
                missed[m] = (missed[m] < 255) ? missed[m] + 1 : 255;
                if (missed[m] >= STALE) begin
                    present[m] = 0; fresh[m] = 1;
                end
            end
            seen[m] = 0;
        end
    endtask

    task automatic check_all();
        logic [4:0] pv;
        for (int m = 0; m < 5; m++) begin
            pv[m] = present[m];
            chk($sformatf("out_x[%0d]", m), 32'(o_x[m]), ox[m]);
            chk($sformatf("out_y[%0d]", m), 32'(o_y[m]), oy[m]);
            chk($sformatf("out_z[%0d]", m), 32'(o_z[m]), oz[m]);
        end
        chk("marker_present", 32'(marker_present), 32'(pv));
        chk("pose_valid", 32'(pose_valid), 32'(&pv));
    endtask

    // All tasks start and end just after a falling edge.
    task automatic send(input int id, input int x, input int y, input int z);
        int waited = 0;
        sif.sample_valid = 1'b1;
        sif.sample_id = 3'(id); sif.sample_x = 12'(x); sif.sample_y = 12'(y); sif.sample_z = 14'(z);
        while (!sif.sample_ready && waited < 4) begin
            @(posedge clk); @(negedge clk); waited++;
        end
        if (!sif.sample_ready) begin
            chk("ready_timeout", 32'(sif.sample_ready), 1);
        end else begin
            @(posedge clk);
            model_sample(id, x, y, z);
            @(negedge clk);
        end
        sif.sample_valid = 1'b0;
    endtask

    task automatic frame();
        sif.frame_done = 1'b1;
        @(posedge clk); @(negedge clk);
        sif.frame_done = 1'b0;
        chk("ready_in_publish", 32'(sif.sample_ready), 0);
        @(posedge clk);
        model_publish();
        @(negedge clk);
        chk("pose_update_pulse", 32'(pose_update), 1);
        chk("overrun_idle", 32'(frame_overrun), 0);
        check_all();
        @(posedge clk); @(negedge clk);
        chk("pose_update_end", 32'(pose_update), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.sample_valid = 1'b0; sif.sample_id = 3'd0; sif.frame_done = 1'b0;
        sif.sample_x = 12'd0; sif.sample_y = 12'd0; sif.sample_z = 14'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", 32'(sif.sample_ready), 0);
        chk("update_in_reset", 32'(pose_update), 0);
        chk("overrun_in_reset", 32'(frame_overrun), 0);
        check_all();
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_after_reset", 32'(sif.sample_ready), 1);

        // First sample of a marker loads directly.
        send(0, 100, 7, 9);
        frame();
`ifndef POSE_MIRROR_X_EN
        chk("first_load_x", 32'(o_x[0]), 100);
`endif
        chk("present_one", 32'(marker_present), 32'h01);

        // Smoothing towards a higher and a lower sample.
        send(0, 200, 7, 9);
        frame();
        send(1, 200, 50, 60);
        frame();
        send(1, 100, 50, 60);
        frame();
`ifndef POSE_MIRROR_X_EN
        chk("smooth_up", 32'(o_x[0]), 125);
        chk("smooth_down", 32'(o_x[1]), 175);
`endif

        // Full pose, then the head goes missing until it is dropped.
        for (int m = 0; m < 5; m++) send(m, 300 + m, 400 + m, 1000 + m);
        frame();
        chk("pose_valid_full", 32'(pose_valid), 1);
        for (int f = 0; f < STALE; f++) begin
            for (int m = 0; m < 4; m++) send(m, 310 + f, 410, 1010);
            frame();
        end
        chk("head_dropped", 32'(marker_present[4]), 0);
        chk("pose_invalid", 32'(pose_valid), 0);
        send(4, 10, 20, 500);
        frame();
        chk("head_direct_load", 32'(o_z[4]), 500);

        // Sample on the frame_done edge, and a sample offered during PUBLISH.
        sif.sample_valid = 1'b1; sif.sample_id = 3'd2;
        sif.sample_x = 12'd1234; sif.sample_y = 12'd222; sif.sample_z = 14'd3333;
        sif.frame_done = 1'b1;
        chk("ready_same_edge", 32'(sif.sample_ready), 1);
        @(posedge clk);
        model_sample(2, 1234, 222, 3333);
        @(negedge clk);
        sif.frame_done = 1'b0;
        sif.sample_id = 3'd3; sif.sample_x = 12'd999; sif.sample_y = 12'd888; sif.sample_z = 14'd7777;
        chk("ready_low_publish", 32'(sif.sample_ready), 0);
        @(posedge clk);
        model_publish();
        @(negedge clk);
        chk("same_edge_update", 32'(pose_update), 1);
        check_all();
        chk("ready_back", 32'(sif.sample_ready), 1);
        @(posedge clk);
        model_sample(3, 999, 888, 7777);
        @(negedge clk);
        sif.sample_valid = 1'b0;
        frame();

        // frame_done on two consecutive edges: one publication, one overrun.
        send(0, 50, 60, 70);
        sif.frame_done = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk);
        model_publish();
        @(negedge clk);
        sif.frame_done = 1'b0;
        chk("overrun_pulse", 32'(frame_overrun), 1);
        chk("overrun_update", 32'(pose_update), 1);
        check_all();
        @(posedge clk); @(negedge clk);
        chk("overrun_end", 32'(frame_overrun), 0);
        chk("no_second_publish", 32'(pose_update), 0);

        // Out-of-range ids are swallowed.
        send(6, 4000, 4000, 16000);
        frame();

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++)
                send($urandom_range(0, 7), $urandom_range(0, 4095),
                     $urandom_range(0, 4095), $urandom_range(0, 16383));
            frame();
        end

        // Reset during PUBLISH aborts the publication.
        send(0, 555, 556, 557);
        sif.frame_done = 1'b1;
        @(posedge clk); @(negedge clk);
        sif.frame_done = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        chk("abort_no_update", 32'(pose_update), 0);
        chk("abort_ready", 32'(sif.sample_ready), 0);
        check_all();
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        send(0, 77, 78, 79);
        frame();
`ifndef POSE_MIRROR_X_EN
        chk("post_reset_load", 32'(o_x[0]), 77);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
